// File: rtl/int_ctrl_if.sv
// Bundle of request lines, mask programming and CPU handshake signals
// between the peripherals/CPU and the interrupt controller.
interface int_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 10
);
  logic [N_SRC-1:0] irq_src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             int_ack;
  logic             int_eoi;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic             in_service;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;

  // Peripheral/CPU side
  modport master (
    output irq_src, mask_we, mask_wdata, int_ack, int_eoi,
    input  int_req, int_vec, in_service, pending, mask
  );

  // Controller side
  modport slave (
    input  irq_src, mask_we, mask_wdata, int_ack, int_eoi,
    output int_req, int_vec, in_service, pending, mask
  );
endinterface

// File: rtl/int_ctrl.sv
// Non-nesting interrupt controller: rising-edge latching, maskable fixed
// priority (lowest index wins) and a req/ack/eoi handshake with the CPU.
module int_ctrl #(
  parameter int               N_SRC    = 4,
  parameter int               VEC_W    = 10,
  parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
  input logic       clk,
  input logic       reset,
  int_ctrl_if.slave bus
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask_reg;
  logic [1:0]       state;
  logic [SEL_W-1:0] sel;
  logic             req;
  logic [VEC_W-1:0] vec;
  logic             svc;

  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [SEL_W-1:0] win;
  logic             any_eligible;
  logic             ack_take;

  // Edge detection, arbitration and the pending-clear mask for an accepted ack
  always_comb begin
    edges        = bus.irq_src & ~irq_q;
    eligible     = pend & mask_reg;
    any_eligible = |eligible;
    ack_take     = (state == REQ) && bus.int_ack;
    win          = '0;
    // Scan high to low so the lowest set index is the last one written
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win = SEL_W'(i);
      end else begin
        win = win;
      end
    end
    if (ack_take) begin
      clr = ONE_HOT0 << sel;
    end else begin
      clr = '0;
    end
  end

  // Request-line history and pending bits; a fresh edge beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= bus.irq_src;
      pend  <= (pend & ~clr) | edges;
    end
  end

  // Mask register, writable in any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_reg <= '0;
    end else if (bus.mask_we) begin
      mask_reg <= bus.mask_wdata;
    end else begin
      mask_reg <= mask_reg;
    end
  end

  // Handshake FSM; sel and vec are frozen from request until end of service
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      req   <= 1'b0;
      vec   <= '0;
      svc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            sel   <= win;
            vec   <= VEC_BASE + VEC_W'(win);
            req   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            req   <= 1'b0;
            svc   <= 1'b1;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.int_eoi) begin
            svc   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req   <= 1'b0;
          svc   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.int_req    = req;
  assign bus.int_vec    = vec;
  assign bus.in_service = svc;
  assign bus.pending    = pend;
  assign bus.mask       = mask_reg;
endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: a behavioural model predicts every cycle's
// status and every request vector; a monitor compares them against the DUT.
// A second instance with VEC_BASE=10'h3FE shares the stimulus (wrap-around).
module tb_int_ctrl;
  logic clk;
  logic reset;

  int_ctrl_if #(.N_SRC(4), .VEC_W(10)) b1 ();
  int_ctrl_if #(.N_SRC(4), .VEC_W(10)) b2 ();

  int_ctrl #(.N_SRC(4), .VEC_W(10), .VEC_BASE(10'h3F0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  int_ctrl #(.N_SRC(4), .VEC_W(10), .VEC_BASE(10'h3FE)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  assign b2.irq_src    = b1.irq_src;
  assign b2.mask_we    = b1.mask_we;
  assign b2.mask_wdata = b1.mask_wdata;
  assign b2.int_ack    = b1.int_ack;
  assign b2.int_eoi    = b1.int_eoi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic [9:0] vec;
    logic       svc;
    logic [3:0] pend;
    logic [3:0] mask;
  } st_t;

  st_t sq[$];
  int  vq[$];
  int  checks = 0;
  int  passes = 0;

  // Reference model state
  bit m_prev[4];
  bit m_pend[4];
  bit m_mask[4];
  int m_phase;   // 0 waiting for work, 1 request outstanding, 2 handler running
  int m_sel;
  bit m_req;
  bit m_svc;
  int m_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_mask[i] = 1'b0;
    end
    m_phase = 0; m_sel = 0; m_req = 1'b0; m_svc = 1'b0; m_vec = 0;
    sq.delete();
    vq.delete();
  endtask

  function automatic logic [3:0] pack4(input bit a[4]);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = a[i];
    return r;
  endfunction

  task automatic model_step(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                            input logic ack, input logic eoi);
    int  winner;
    st_t s;
    winner = -1;
    for (int i = 0; i < 4; i++)
      if (winner < 0 && m_pend[i] && m_mask[i]) winner = i;
    if (m_phase == 0) begin
      if (winner >= 0) begin
        m_sel = winner;
        m_vec = (1008 + winner) % 1024;
        m_req = 1'b1;
        m_phase = 1;
        vq.push_back(winner);
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        m_pend[m_sel] = 1'b0;
        m_req = 1'b0;
        m_svc = 1'b1;
        m_phase = 2;
      end
    end else begin
      if (eoi) begin
        m_svc = 1'b0;
        m_phase = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (src[i] && !m_prev[i]) m_pend[i] = 1'b1;
      if (mwe) m_mask[i] = mwd[i];
      m_prev[i] = src[i];
    end
    s.req = m_req; s.vec = 10'(m_vec); s.svc = m_svc;
    s.pend = pack4(m_pend); s.mask = pack4(m_mask);
    sq.push_back(s);
  endtask

  // Drive one cycle's inputs at the falling edge and advance the model
  task automatic cycle(input logic [3:0] src, input logic mwe, input logic [3:0] mwd,
                       input logic ack, input logic eoi);
    @(negedge clk);
    b1.irq_src = src; b1.mask_we = mwe; b1.mask_wdata = mwd;
    b1.int_ack = ack; b1.int_eoi = eoi;
    model_step(src, mwe, mwd, ack, eoi);
  endtask

  task automatic idle();
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Monitor: per-cycle status and request vectors from both instances
  initial begin
    st_t e;
    bit  req_seen;
    int  s;
    req_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("int_req", 32'(b1.int_req), 32'(e.req));
        chk("in_service", 32'(b1.in_service), 32'(e.svc));
        chk("pending", 32'(b1.pending), 32'(e.pend));
        chk("mask", 32'(b1.mask), 32'(e.mask));
        if (e.req || e.svc) chk("int_vec", 32'(b1.int_vec), 32'(e.vec));
      end
      if (b1.int_req && !req_seen) begin
        if (vq.size() == 0) begin
          chk("unexpected_req", 32'(1), 32'(0));
        end else begin
          s = vq.pop_front();
          chk("req_vec", 32'(b1.int_vec), 32'((1008 + s) % 1024));
          chk("wrap_vec", 32'(b2.int_vec), 32'((1022 + s) % 1024));
        end
      end
      req_seen = b1.int_req;
    end
  end

  initial begin
    b1.irq_src = 4'b0000; b1.mask_we = 1'b0; b1.mask_wdata = 4'b0000;
    b1.int_ack = 1'b0; b1.int_eoi = 1'b0;
    model_reset();
    reset = 1'b1;
    #1;
    chk("rst_req", 32'(b1.int_req), 32'(0));
    chk("rst_svc", 32'(b1.in_service), 32'(0));
    chk("rst_pend", 32'(b1.pending), 32'(0));
    chk("rst_mask", 32'(b1.mask), 32'(0));
    chk("rst_vec", 32'(b1.int_vec), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Source 0 edge with everything masked: latched, no request
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(); sample();
    chk("masked_pend", 32'(b1.pending), 32'(4'b0001));
    chk("masked_req", 32'(b1.int_req), 32'(0));
    // Mask leaves source 0 disabled, then enable it
    cycle(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0);
    idle(); idle(); sample();
    chk("mask1110_req", 32'(b1.int_req), 32'(0));
    cycle(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    idle(); sample();
    chk("unmask_req", 32'(b1.int_req), 32'(1));
    chk("unmask_vec", 32'(b1.int_vec), 32'(10'h3F0));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Basic handshake on source 2
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(); sample();
    chk("basic_req", 32'(b1.int_req), 32'(1));
    chk("basic_vec", 32'(b1.int_vec), 32'(10'h3F2));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); sample();
    chk("basic_svc", 32'(b1.in_service), 32'(1));
    chk("basic_pend2", 32'(b1.pending[2]), 32'(0));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); sample();
    chk("basic_eoi", 32'(b1.in_service), 32'(0));

    // Simultaneous edges on 3 and 1: 1 first, 3 one cycle after its EOI
    cycle(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(); sample();
    chk("prio_vec1", 32'(b1.int_vec), 32'(10'h3F1));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle(); sample();
    chk("prio_req3", 32'(b1.int_req), 32'(1));
    chk("prio_vec3", 32'(b1.int_vec), 32'(10'h3F3));
    chk("wrap_src3", 32'(b2.int_vec), 32'(10'h001));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Higher-priority edge during REQ does not retarget
    cycle(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(); sample();
    chk("no_retarget", 32'(b1.int_vec), 32'(10'h3F1));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle();
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

    // New edge on sel in the ack cycle survives the clear
    cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(); idle();
    cycle(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0); sample();
    chk("coll_pend", 32'(b1.pending), 32'(4'b0100));
    chk("coll_svc", 32'(b1.in_service), 32'(1));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle(); sample();
    chk("coll_rereq", 32'(b1.int_req), 32'(1));
    chk("coll_vec", 32'(b1.int_vec), 32'(10'h3F2));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Stray ack in IDLE, stray eoi in REQ, ack+eoi together in REQ
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); sample();
    chk("stray_ack", 32'(b1.in_service), 32'(0));
    cycle(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); sample();
    chk("stray_eoi", 32'(b1.int_req), 32'(1));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1); sample();
    chk("ack_eoi_svc", 32'(b1.in_service), 32'(1));
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset while a request is outstanding
    cycle(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(b1.int_req), 32'(0));
    chk("mid_rst_svc", 32'(b1.in_service), 32'(0));
    chk("mid_rst_pend", 32'(b1.pending), 32'(0));
    chk("mid_rst_mask", 32'(b1.mask), 32'(0));
    chk("mid_rst_vec", 32'(b1.int_vec), 32'(0));
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(); sample();
    chk("post_rst_pend", 32'(b1.pending), 32'(4'b0001));
    chk("post_rst_req", 32'(b1.int_req), 32'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      cycle(4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 9) < 4));
    end
    idle(); sample();
    chk("queue_drained", 32'(sq.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
